// File: rtl/wb_daq_channel_arbiter_pkg.sv
// Shared definitions for the DAQ channel arbiter slice.
// Contents:
//   DAQ_CH_ID_W  - width of the channel id tag carried alongside each sample
//   DAQ_MAX_CH   - largest number of channels the id tag can address
//   id_to_onehot - expands a channel id into a one-hot channel mask
package wb_daq_channel_arbiter_pkg;

    localparam int DAQ_CH_ID_W = 3;
    localparam int DAQ_MAX_CH  = 8;

    function automatic logic [DAQ_MAX_CH-1:0] id_to_onehot(input logic [DAQ_CH_ID_W-1:0] id);
        logic [DAQ_MAX_CH-1:0] mask;
        mask = {{(DAQ_MAX_CH-1){1'b0}}, 1'b1} << id;
        return mask;
    endfunction

endpackage

// File: rtl/wb_daq_channel_arbiter_rr_arbiter.sv
// Combinational round-robin grant for the DAQ channel arbiter.
// Ports:
//   req         - per-channel request (pending) vector
//   last_grant  - channel granted most recently; search starts one above it
//   grant_valid - at least one request is present
//   grant_idx   - winning channel index, valid while grant_valid=1
module wb_daq_rr_arbiter
    import wb_daq_channel_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]      req,
    input  logic [DAQ_CH_ID_W-1:0] last_grant,
    output logic                   grant_valid,
    output logic [DAQ_CH_ID_W-1:0] grant_idx
);

    int dist_s;
    int best_dist_s;

    // Each channel's distance from last_grant+1 (mod NUM_CH); the nearest
    // requester wins. Using constant channel indices avoids variable selects.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_dist_s = NUM_CH;
        dist_s      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            dist_s = (k + NUM_CH - 1 - int'(last_grant)) % NUM_CH;
            if (req[k] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                grant_valid = 1'b1;
                grant_idx   = DAQ_CH_ID_W'(k);
            end else begin
            end
        end
    end

endmodule

// File: rtl/wb_daq_channel_arbiter.sv
// Shares the aggregation datapath between NUM_CH ADC channels. Each channel
// owns a one-sample holding register; a round-robin scheduler forwards one
// held sample per cycle, tagged with its channel id.
// Ports:
//   wb_clk, wb_rst - clock and synchronous active-high reset
//   ch_enable      - per-channel enable; low discards that channel's pending sample
//   ch_valid       - per-channel one-cycle sample strobe
//   ch_data        - packed samples, channel i at [i*adc_dw +: adc_dw]
//   overrun_clr    - clears all sticky overrun flags
//   data_ready     - one-cycle strobe, adc_data_out/ch_id valid
//   adc_data_out   - granted sample
//   ch_id          - granted channel index
//   overrun        - sticky per-channel overrun flags
//   busy           - any holding register pending
module wb_daq_channel_arbiter
    import wb_daq_channel_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int adc_dw = 8
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*adc_dw-1:0] ch_data,
    input  logic                     overrun_clr,
    output logic                     data_ready,
    output logic [adc_dw-1:0]        adc_data_out,
    output logic [DAQ_CH_ID_W-1:0]   ch_id,
    output logic [NUM_CH-1:0]        overrun,
    output logic                     busy
);

    logic [adc_dw-1:0]      hold_r [NUM_CH];
    logic [NUM_CH-1:0]      pending_r;
    logic [NUM_CH-1:0]      overrun_r;
    logic [DAQ_CH_ID_W-1:0] last_grant_r;
    logic                   data_ready_r;
    logic [adc_dw-1:0]      adc_data_r;
    logic [DAQ_CH_ID_W-1:0] ch_id_r;
    logic                   busy_r;

    logic [NUM_CH-1:0]      capture_s;
    logic [NUM_CH-1:0]      pending_nxt_s;
    logic [NUM_CH-1:0]      overrun_nxt_s;
    logic                   grant_valid_s;
    logic [DAQ_CH_ID_W-1:0] grant_idx_s;
    logic [DAQ_MAX_CH-1:0]  grant_onehot_s;
    logic [NUM_CH-1:0]      grant_vec_s;
    logic [adc_dw-1:0]      grant_data_s;

    wb_daq_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr (
        .req         (pending_r),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Decode the grant into a channel mask and select the held sample.
    always_comb begin
        grant_onehot_s = id_to_onehot(grant_idx_s);
        if (grant_valid_s) begin
            grant_vec_s = grant_onehot_s[NUM_CH-1:0];
        end else begin
            grant_vec_s = '0;
        end
        grant_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_vec_s[i]) begin
                grant_data_s = hold_r[i];
            end else begin
            end
        end
    end

    // Next pending/overrun state. A capture always leaves the channel pending
    // (even when its old sample is granted this cycle); overrun is only
    // flagged when a still-waiting sample gets overwritten, and beats a clear.
    always_comb begin
        capture_s     = ch_valid & ch_enable;
        pending_nxt_s = pending_r;
        overrun_nxt_s = overrun_r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture_s[i]) begin
                pending_nxt_s[i] = 1'b1;
            end else if (!ch_enable[i] || grant_vec_s[i]) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end

            if (capture_s[i] && pending_r[i] && !grant_vec_s[i]) begin
                overrun_nxt_s[i] = 1'b1;
            end else if (overrun_clr) begin
                overrun_nxt_s[i] = 1'b0;
            end else begin
                overrun_nxt_s[i] = overrun_r[i];
            end
        end
    end

    // Holding registers, scheduler state and registered outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold_r[i] <= '0;
            end
            pending_r    <= '0;
            overrun_r    <= '0;
            last_grant_r <= DAQ_CH_ID_W'(NUM_CH - 1);
            data_ready_r <= 1'b0;
            adc_data_r   <= '0;
            ch_id_r      <= '0;
            busy_r       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture_s[i]) begin
                    hold_r[i] <= ch_data[i*adc_dw +: adc_dw];
                end
            end
            pending_r <= pending_nxt_s;
            overrun_r <= overrun_nxt_s;
            busy_r    <= |pending_nxt_s;
            if (grant_valid_s) begin
                data_ready_r <= 1'b1;
                adc_data_r   <= grant_data_s;
                ch_id_r      <= grant_idx_s;
                last_grant_r <= grant_idx_s;
            end else begin
                data_ready_r <= 1'b0;
            end
        end
    end

    assign data_ready   = data_ready_r;
    assign adc_data_out = adc_data_r;
    assign ch_id        = ch_id_r;
    assign overrun      = overrun_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_wb_daq_channel_arbiter.sv
module tb_wb_daq_channel_arbiter;

    logic        wb_clk;
    logic        wb_rst;
    logic [3:0]  ch_enable;
    logic [3:0]  ch_valid;
    logic [31:0] ch_data;
    logic        overrun_clr;
    logic        data_ready;
    logic [7:0]  adc_data_out;
    logic [2:0]  ch_id;
    logic [3:0]  overrun;
    logic        busy;

    int tests_run;
    int tests_failed;

    wb_daq_channel_arbiter #(.NUM_CH(4), .adc_dw(8)) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .ch_enable    (ch_enable),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .overrun_clr  (overrun_clr),
        .data_ready   (data_ready),
        .adc_data_out (adc_data_out),
        .ch_id        (ch_id),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic reset_dut();
        wb_rst = 1'b1;
        ch_valid = 4'b0000;
        ch_enable = 4'b1111;
        overrun_clr = 1'b0;
        ch_data = 32'h0;
        tick();
        wb_rst = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        ch_valid = 4'b0000;
        ch_enable = 4'b1111;
        overrun_clr = 1'b0;
        ch_data = 32'h0;
        tick();
        tick();
        tests_run++;
        if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_dr: got %0b exp 0", data_ready); end
        tests_run++;
        if (adc_data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h exp 00", adc_data_out); end
        tests_run++;
        if (ch_id !== 3'd0) begin tests_failed++; $display("FAIL reset_id: got %0d exp 0", ch_id); end
        tests_run++;
        if (overrun !== 4'b0000) begin tests_failed++; $display("FAIL reset_ovr: got %b exp 0000", overrun); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        wb_rst = 1'b0;
    endtask

    task automatic test_single();
        reset_dut();
        ch_valid = 4'b0001;
        ch_data = 32'h0000_00A5;
        tick();
        ch_valid = 4'b0000;
        tests_run++;
        if (data_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_capture: dr=%0b busy=%0b exp dr=0 busy=1", data_ready, busy); end
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || adc_data_out !== 8'hA5 || ch_id !== 3'd0) begin
            tests_failed++; $display("FAIL single_grant: dr=%0b data=%h id=%0d exp 1 a5 0", data_ready, adc_data_out, ch_id);
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b0 || busy !== 1'b0 || overrun !== 4'b0000) begin
            tests_failed++; $display("FAIL single_after: dr=%0b busy=%0b ovr=%b exp 0 0 0000", data_ready, busy, overrun);
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        ch_valid = 4'b1111;
        ch_data = 32'h1312_1110;
        tick();
        ch_valid = 4'b0000;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL simul_busy0: got %0b exp 1", busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (data_ready !== 1'b1 || ch_id !== 3'(k) || adc_data_out !== 8'(8'h10 + k)) begin
                tests_failed++; $display("FAIL simul_grant%0d: dr=%0b id=%0d data=%h exp 1 %0d %h", k, data_ready, ch_id, adc_data_out, k, 8'(8'h10 + k));
            end
            tests_run++;
            if (busy !== (k < 3)) begin tests_failed++; $display("FAIL simul_busy%0d: got %0b exp %0b", k + 1, busy, (k < 3)); end
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL simul_end: dr=%0b exp 0", data_ready); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_id;
        logic [7:0] exp_data;
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            ch_valid = 4'b1010;
            ch_data = {8'(8'h80 + i), 8'h00, 8'(8'h40 + i), 8'h00};
            tick();
            if (i >= 1) begin
                exp_id = (i % 2 == 1) ? 3'd1 : 3'd3;
                exp_data = ((i % 2 == 1) ? 8'h40 : 8'h80) + 8'(i - 1);
                tests_run++;
                if (data_ready !== 1'b1 || ch_id !== exp_id || adc_data_out !== exp_data) begin
                    tests_failed++; $display("FAIL rr_cycle%0d: dr=%0b id=%0d data=%h exp 1 %0d %h", i, data_ready, ch_id, adc_data_out, exp_id, exp_data);
                end
            end
        end
        ch_valid = 4'b0000;
        tests_run++;
        if (overrun !== 4'b1010) begin tests_failed++; $display("FAIL rr_overrun: got %b exp 1010", overrun); end
        tick();
        tick();
        tick();
    endtask

    task automatic test_overrun();
        reset_dut();
        ch_valid = 4'b0111;
        ch_data = 32'h0055_A1A0;
        tick();
        ch_valid = 4'b0100;
        ch_data = 32'h0066_0000;
        tick();
        ch_valid = 4'b0000;
        tests_run++;
        if (data_ready !== 1'b1 || ch_id !== 3'd0 || adc_data_out !== 8'hA0) begin
            tests_failed++; $display("FAIL ovr_g0: dr=%0b id=%0d data=%h exp 1 0 a0", data_ready, ch_id, adc_data_out);
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || ch_id !== 3'd1 || adc_data_out !== 8'hA1) begin
            tests_failed++; $display("FAIL ovr_g1: dr=%0b id=%0d data=%h exp 1 1 a1", data_ready, ch_id, adc_data_out);
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || ch_id !== 3'd2 || adc_data_out !== 8'h66) begin
            tests_failed++; $display("FAIL ovr_g2: dr=%0b id=%0d data=%h exp 1 2 66", data_ready, ch_id, adc_data_out);
        end
        tests_run++;
        if (overrun !== 4'b0100) begin tests_failed++; $display("FAIL ovr_flag: got %b exp 0100", overrun); end
        tick();
        tests_run++;
        if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL ovr_drained: dr=%0b exp 0", data_ready); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 4'b0000) begin tests_failed++; $display("FAIL ovr_clear: got %b exp 0000", overrun); end
        // last grant was 2, so channel 0 wins next and channel 2 is overwritten while waiting
        ch_valid = 4'b0101;
        ch_data = 32'h0002_0001;
        tick();
        ch_valid = 4'b0100;
        ch_data = 32'h0003_0000;
        overrun_clr = 1'b1;
        tick();
        ch_valid = 4'b0000;
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 4'b0100) begin tests_failed++; $display("FAIL ovr_set_beats_clr: got %b exp 0100", overrun); end
        tests_run++;
        if (data_ready !== 1'b1 || ch_id !== 3'd0 || adc_data_out !== 8'h01) begin
            tests_failed++; $display("FAIL ovr_coinc_grant: dr=%0b id=%0d data=%h exp 1 0 01", data_ready, ch_id, adc_data_out);
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || ch_id !== 3'd2 || adc_data_out !== 8'h03) begin
            tests_failed++; $display("FAIL ovr_coinc_g2: dr=%0b id=%0d data=%h exp 1 2 03", data_ready, ch_id, adc_data_out);
        end
    endtask

    task automatic test_disable();
        reset_dut();
        ch_valid = 4'b0011;
        ch_data = 32'h0000_2221;
        tick();
        ch_valid = 4'b0000;
        ch_enable = 4'b1101;
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || ch_id !== 3'd0 || adc_data_out !== 8'h21) begin
            tests_failed++; $display("FAIL dis_g0: dr=%0b id=%0d data=%h exp 1 0 21", data_ready, ch_id, adc_data_out);
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL dis_busy: got %0b exp 0", busy); end
        ch_enable = 4'b1111;
        tick();
        tests_run++;
        if (data_ready !== 1'b0 || overrun !== 4'b0000) begin
            tests_failed++; $display("FAIL dis_no_out: dr=%0b ovr=%b exp 0 0000", data_ready, overrun);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            ch_valid = 4'b0001;
            ch_data = {24'h0, 8'(8'h30 + i)};
            tick();
            if (i >= 1) begin
                tests_run++;
                if (data_ready !== 1'b1 || ch_id !== 3'd0 || adc_data_out !== 8'(8'h30 + i - 1)) begin
                    tests_failed++; $display("FAIL b2b_%0d: dr=%0b id=%0d data=%h exp 1 0 %h", i, data_ready, ch_id, adc_data_out, 8'(8'h30 + i - 1));
                end
            end
        end
        ch_valid = 4'b0000;
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || adc_data_out !== 8'h35 || overrun !== 4'b0000) begin
            tests_failed++; $display("FAIL b2b_last: dr=%0b data=%h ovr=%b exp 1 35 0000", data_ready, adc_data_out, overrun);
        end
    endtask

    task automatic test_reset_midburst();
        reset_dut();
        ch_valid = 4'b1111;
        ch_data = 32'h0403_0201;
        tick();
        ch_valid = 4'b0000;
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || adc_data_out !== 8'h01) begin
            tests_failed++; $display("FAIL mid_first: dr=%0b data=%h exp 1 01", data_ready, adc_data_out);
        end
        wb_rst = 1'b1;
        tick();
        tests_run++;
        if (data_ready !== 1'b0 || adc_data_out !== 8'h00 || ch_id !== 3'd0 || overrun !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset: dr=%0b data=%h id=%0d ovr=%b busy=%0b exp all 0", data_ready, adc_data_out, ch_id, overrun, busy);
        end
        wb_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (data_ready !== 1'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL mid_after%0d: dr=%0b busy=%0b exp 0 0", i, data_ready, busy);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overrun();
        test_disable();
        test_back_to_back();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
